// File: rtl/state_reg_bank.sv
// rtl/state_reg_bank.sv - multi-word ASCON state register with per-word write ops and update counter
// Optional STATE_BANK_PARITY_EN adds a per-word even-parity bit and a registered parity_err_o.
module state_reg_bank #(
  parameter int                WIDTH    = 64,
  parameter int                NWORDS   = 5,
  parameter logic [WIDTH-1:0]  INIT_VAL = '0,
  parameter int                CNT_W    = 8
) (
  input  logic                      clock_i,
  input  logic                      resetb_i,
  input  logic [NWORDS-1:0]         en_i,
  input  logic [1:0]                op_i,
  input  logic [NWORDS*WIDTH-1:0]   d_i,
  input  logic                      cnt_clr_i,
  output logic [NWORDS*WIDTH-1:0]   q_o,
  output logic                      upd_o,
  output logic [CNT_W-1:0]          cnt_o
`ifdef STATE_BANK_PARITY_EN
  ,
  output logic                      parity_err_o
`endif
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_XOR   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_INIT  = 2'b11
  } op_e;

  logic [WIDTH-1:0] r_q      [NWORDS];
  logic [WIDTH-1:0] w_q_next [NWORDS];
  logic             r_upd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_write;
  logic             w_cnt_sat;
  op_e              w_op;

  assign w_op      = op_e'(op_i);
  assign w_write   = |en_i;
  assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}});

  // Words without an enable keep their value whatever op_i/d_i carry.
  always_comb begin
    for (int k = 0; k < NWORDS; k++) begin
      w_q_next[k] = r_q[k];
      if (en_i[k]) begin
        case (w_op)
          OP_LOAD:  w_q_next[k] = d_i[k*WIDTH +: WIDTH];
          OP_XOR:   w_q_next[k] = r_q[k] ^ d_i[k*WIDTH +: WIDTH];
          OP_CLEAR: w_q_next[k] = '0;
          OP_INIT:  w_q_next[k] = INIT_VAL;
          default:  w_q_next[k] = r_q[k];
        endcase
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int k = 0; k < NWORDS; k++) begin
        r_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NWORDS; k++) begin
        r_q[k] <= w_q_next[k];
      end
    end
  end

  // Counter clear takes priority over a simultaneous write; saturates instead of wrapping.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_upd <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_upd <= w_write;
      if (cnt_clr_i) begin
        r_cnt <= '0;
      end else if (w_write && !w_cnt_sat) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NWORDS; g++) begin : g_q_pack
    assign q_o[g*WIDTH +: WIDTH] = r_q[g];
  end

  assign upd_o = r_upd;
  assign cnt_o = r_cnt;

`ifdef STATE_BANK_PARITY_EN
  logic [NWORDS-1:0] r_par;
  logic [NWORDS-1:0] w_par_mismatch;
  logic              r_perr;

  always_comb begin
    for (int k = 0; k < NWORDS; k++) begin
      w_par_mismatch[k] = (^r_q[k]) ^ r_par[k];
    end
  end

  // Parity is computed from the value being written so it tracks the stored word.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_par  <= '0;
      r_perr <= 1'b0;
    end else begin
      for (int k = 0; k < NWORDS; k++) begin
        if (en_i[k]) begin
          r_par[k] <= ^w_q_next[k];
        end
      end
      r_perr <= |w_par_mismatch;
    end
  end

  assign parity_err_o = r_perr;
`endif

endmodule

// File: tb/tb_state_reg_bank.sv
// tb/tb_state_reg_bank.sv - randomized self-checking bench for state_reg_bank
// Parity scenario is included when STATE_BANK_PARITY_EN is defined.
module tb_state_reg_bank;

  localparam int          W     = 64;
  localparam int          N     = 5;
  localparam int          CW    = 4;
  localparam logic [63:0] IVAL  = 64'h80400c0600000000;
  localparam int          CMAX  = (1 << CW) - 1;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   en;
  logic [1:0]     op;
  logic [N*W-1:0] d;
  logic           clr;
  logic [N*W-1:0] q;
  logic           upd;
  logic [CW-1:0]  cnt;
`ifdef STATE_BANK_PARITY_EN
  logic           perr;
`endif

  logic [63:0] stim_d [N];
  logic [63:0] m_q    [N];
  int          m_cnt;
  logic        m_upd;
  int          errors;
  int          checks;

  state_reg_bank #(
    .WIDTH(W), .NWORDS(N), .INIT_VAL(IVAL), .CNT_W(CW)
  ) dut (
    .clock_i(clk),
    .resetb_i(rst_n),
    .en_i(en),
    .op_i(op),
    .d_i(d),
    .cnt_clr_i(clr),
    .q_o(q),
    .upd_o(upd),
    .cnt_o(cnt)
`ifdef STATE_BANK_PARITY_EN
    ,
    .parity_err_o(perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_q[k] = 64'h0;
    m_cnt = 0;
    m_upd = 1'b0;
  endtask

  // Drive one cycle from stim_d, advance the reference model, return at the falling edge.
  task automatic cycle(input logic [N-1:0] c_en, input logic [1:0] c_op, input logic c_clr);
    en  = c_en;
    op  = c_op;
    clr = c_clr;
    for (int k = 0; k < N; k++) d[k*W +: W] = stim_d[k];
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (c_en[k]) begin
        if (c_op == 2'd0)      m_q[k] = stim_d[k];
        else if (c_op == 2'd1) m_q[k] = m_q[k] ^ stim_d[k];
        else if (c_op == 2'd2) m_q[k] = 64'h0;
        else                   m_q[k] = IVAL;
      end
    end
    if (c_clr)                           m_cnt = 0;
    else if (c_en != 0 && m_cnt < CMAX)  m_cnt = m_cnt + 1;
    m_upd = (c_en != 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = '0; op = '0; d = '0; clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (q !== '0) begin errors++; $display("FAIL reset_q got=%h want=0", q); end
    checks++;
    if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b want=0", upd); end
    checks++;
    if (cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_all();
    for (int k = 0; k < N; k++) stim_d[k] = 64'h0123456789ABCDEF + 64'(k);
    cycle(5'h1F, 2'b00, 1'b0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (q[k*W +: W] !== 64'h0123456789ABCDEF + 64'(k)) begin
        errors++; $display("FAIL load_all_w%0d got=%h want=%h", k, q[k*W +: W], 64'h0123456789ABCDEF + 64'(k));
      end
    end
    checks++;
    if (upd !== 1'b1) begin errors++; $display("FAIL load_all_upd got=%b want=1", upd); end
    checks++;
    if (cnt !== 4'd1) begin errors++; $display("FAIL load_all_cnt got=%0d want=1", cnt); end
  endtask

  task automatic test_xor_partial();
    for (int k = 0; k < N; k++) stim_d[k] = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle(5'b00101, 2'b01, 1'b0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (q[k*W +: W] !== m_q[k]) begin
        errors++; $display("FAIL xor_partial_w%0d got=%h want=%h", k, q[k*W +: W], m_q[k]);
      end
    end
    checks++;
    if (q[0 +: W] !== ~(64'h0123456789ABCDEF)) begin
      errors++; $display("FAIL xor_w0_inverted got=%h want=%h", q[0 +: W], ~(64'h0123456789ABCDEF));
    end
    checks++;
    if (cnt !== 4'd2) begin errors++; $display("FAIL xor_cnt got=%0d want=2", cnt); end
  endtask

  task automatic test_clear_init();
    for (int k = 0; k < N; k++) stim_d[k] = {$urandom, $urandom};
    cycle(5'b10000, 2'b10, 1'b0);
    checks++;
    if (q[4*W +: W] !== 64'h0) begin errors++; $display("FAIL clear_w4 got=%h want=0", q[4*W +: W]); end
    cycle(5'b00010, 2'b11, 1'b0);
    checks++;
    if (q[1*W +: W] !== IVAL) begin errors++; $display("FAIL init_w1 got=%h want=%h", q[1*W +: W], IVAL); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (q[k*W +: W] !== m_q[k]) begin
        errors++; $display("FAIL clear_init_w%0d got=%h want=%h", k, q[k*W +: W], m_q[k]);
      end
    end
    cycle(5'b00000, 2'b00, 1'b0);
    checks++;
    if (upd !== 1'b0) begin errors++; $display("FAIL idle_upd got=%b want=0", upd); end
    checks++;
    if (cnt !== 4'd4) begin errors++; $display("FAIL idle_cnt got=%0d want=4", cnt); end
  endtask

  task automatic test_counter();
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N; k++) stim_d[k] = {$urandom, $urandom};
      cycle(5'b00001, 2'b00, 1'b0);
      checks++;
      if (cnt !== m_cnt[CW-1:0] || upd !== 1'b1) begin
        errors++; $display("FAIL counter_step%0d got=%0d/%b want=%0d/1", i, cnt, upd, m_cnt);
      end
    end
    checks++;
    if (cnt !== 4'd15) begin errors++; $display("FAIL counter_sat got=%0d want=15", cnt); end
    cycle(5'b01000, 2'b00, 1'b1);
    checks++;
    if (cnt !== 4'd0) begin errors++; $display("FAIL counter_clr_wins got=%0d want=0", cnt); end
    checks++;
    if (upd !== 1'b1) begin errors++; $display("FAIL counter_clr_upd got=%b want=1", upd); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < N; k++) stim_d[k] = {$urandom, $urandom};
      cycle(5'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0));
      for (int k = 0; k < N; k++) begin
        checks++;
        if (q[k*W +: W] !== m_q[k]) begin
          errors++; $display("FAIL random_c%0d_w%0d got=%h want=%h", i, k, q[k*W +: W], m_q[k]);
        end
      end
      checks++;
      if (upd !== m_upd || cnt !== m_cnt[CW-1:0]) begin
        errors++; $display("FAIL random_c%0d_upd_cnt got=%b/%0d want=%b/%0d", i, upd, cnt, m_upd, m_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N; k++) stim_d[k] = {$urandom, $urandom};
      cycle(5'h1F, 2'b01, 1'b0);
      checks++;
      if (upd !== 1'b1) begin errors++; $display("FAIL b2b_upd%0d got=%b want=1", i, upd); end
    end
  endtask

  task automatic test_async_reset();
    stim_d[2] = 64'hDEAD_BEEF_0000_0001;
    cycle(5'b00100, 2'b00, 1'b0);
    for (int k = 0; k < N; k++) stim_d[k] = {$urandom, $urandom};
    en = 5'h1F; op = 2'b00; clr = 1'b0;
    for (int k = 0; k < N; k++) d[k*W +: W] = stim_d[k];
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== '0) begin errors++; $display("FAIL async_reset_q got=%h want=0", q); end
    checks++;
    if (upd !== 1'b0 || cnt !== '0) begin
      errors++; $display("FAIL async_reset_upd_cnt got=%b/%0d want=0/0", upd, cnt);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (q !== '0 || upd !== 1'b0 || cnt !== '0) begin
      errors++; $display("FAIL reset_held got=%b/%0d q_nonzero=%b want=0/0/0", upd, cnt, (q != '0));
    end
    rst_n = 1'b1;
    model_reset();
    cycle(5'b00000, 2'b00, 1'b0);
    checks++;
    if (q !== '0 || upd !== 1'b0 || cnt !== '0) begin
      errors++; $display("FAIL after_reset got=%b/%0d q_nonzero=%b want=0/0/0", upd, cnt, (q != '0));
    end
  endtask

`ifdef STATE_BANK_PARITY_EN
  task automatic test_parity();
    for (int k = 0; k < N; k++) stim_d[k] = {$urandom, $urandom};
    cycle(5'h1F, 2'b00, 1'b0);
    cycle(5'b00000, 2'b00, 1'b0);
    checks++;
    if (perr !== 1'b0) begin errors++; $display("FAIL parity_clean got=%b want=0", perr); end
    dut.r_q[3][7] = ~dut.r_q[3][7];
    cycle(5'b00000, 2'b00, 1'b0);
    checks++;
    if (perr !== 1'b1) begin errors++; $display("FAIL parity_detect got=%b want=1", perr); end
    cycle(5'b01000, 2'b00, 1'b0);
    cycle(5'b00000, 2'b00, 1'b0);
    checks++;
    if (perr !== 1'b0) begin errors++; $display("FAIL parity_recover got=%b want=0", perr); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load_all();
    test_xor_partial();
    test_clear_init();
    test_counter();
    test_back_to_back();
    test_random();
`ifdef STATE_BANK_PARITY_EN
    test_parity();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
